// File: rtl/note_track_recorder.sv
`default_nettype none
// ============================================================================
// note_track_recorder : run-length multi-track note recorder / player
// Rev 1.0
// ============================================================================
module note_track_recorder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int DUR_WIDTH  = 16,
    parameter int TRACKS     = 2,
    localparam int AW        = $clog2(DEPTH),
    localparam int TW        = (TRACKS > 1) ? $clog2(TRACKS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_i,
    input  logic [TW-1:0]         track_sel_i,
    input  logic                  rec_en_i,
    input  logic [DATA_WIDTH-1:0] note_i,
    input  logic                  clear_i,
    input  logic                  play_start_i,
    input  logic                  play_stop_i,
    input  logic                  loop_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_note_o,
    output logic [DUR_WIDTH-1:0]  out_dur_o,
    output logic                  play_done_o,
    output logic                  busy_o,
    output logic                  full_o,
    output logic                  overflow_o,
    output logic [AW:0]           count_o
);

    localparam int NTRK  = 1 << TW;
    localparam int NSLOT = NTRK * DEPTH;
    localparam int EW    = DATA_WIDTH + DUR_WIDTH;
    localparam logic [AW:0]          CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [DUR_WIDTH-1:0] DUR_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REC  = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    state_t                state_q;
    logic [TW-1:0]         trk_q;
    logic [DATA_WIDTH-1:0] run_note_q;
    logic [DUR_WIDTH-1:0]  run_dur_q;
    logic [AW-1:0]         idx_q;
    logic                  load_q;
    logic [EW-1:0]         rd_q;
    logic [AW:0]           count_q [NTRK];
    logic [NTRK-1:0]       ovf_q;
    logic [EW-1:0]         mem_q [NSLOT];
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_note_q;
    logic [DUR_WIDTH-1:0]  out_dur_q;
    logic                  play_done_q;

    logic [TW-1:0]         act_trk;
    logic [AW:0]           act_cnt;
    logic [AW:0]           rec_cnt;
    logic                  note_chg;
    logic                  commit;
    logic                  wr_en;
    logic                  wr_drop;
    logic [TW+AW-1:0]      wr_addr;
    logic [DUR_WIDTH-1:0]  dur_inc;
    logic                  start_ok;
    logic                  accept;
    logic                  last;
    logic [AW-1:0]         idx_nxt;
    logic                  rd_en;
    logic [TW+AW-1:0]      rd_addr;

    // Outside IDLE the latched track is the active one; in IDLE the selector is.
    assign act_trk  = (state_q == S_IDLE) ? track_sel_i : trk_q;
    assign act_cnt  = count_q[act_trk];
    assign rec_cnt  = count_q[trk_q];

    assign note_chg = (note_i != run_note_q);
    assign commit   = (state_q == S_REC) && (!rec_en_i || note_chg) && (run_dur_q != '0);
    assign wr_en    = commit && (rec_cnt != CNT_FULL);
    assign wr_drop  = commit && (rec_cnt == CNT_FULL);
    assign wr_addr  = {trk_q, rec_cnt[AW-1:0]};
    assign dur_inc  = (run_dur_q == DUR_MAX) ? run_dur_q : run_dur_q + DUR_WIDTH'(1);

    assign start_ok = (state_q == S_IDLE) && !rec_en_i && play_start_i && (act_cnt != '0);
    assign accept   = (state_q == S_PLAY) && out_valid_q && out_ready_i && !play_stop_i;
    assign last     = ({1'b0, idx_q} == (rec_cnt - (AW+1)'(1)));
    assign idx_nxt  = last ? '0 : idx_q + AW'(1);
    // Next entry is fetched on the accept edge so it lands one bubble cycle later.
    assign rd_en    = start_ok || (accept && (!last || loop_i));
    assign rd_addr  = start_ok ? {track_sel_i, {AW{1'b0}}} : {trk_q, idx_nxt};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= {run_note_q, run_dur_q};
        end
        if (rd_en) begin
            rd_q <= mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            trk_q       <= '0;
            run_note_q  <= '0;
            run_dur_q   <= '0;
            idx_q       <= '0;
            load_q      <= 1'b0;
            ovf_q       <= '0;
            for (int i = 0; i < NTRK; i++) begin
                count_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_note_q  <= '0;
            out_dur_q   <= '0;
            play_done_q <= 1'b0;
        end else begin
            play_done_q <= 1'b0;
            load_q      <= rd_en;
            if (wr_en) begin
                count_q[trk_q] <= rec_cnt + (AW+1)'(1);
            end
            if (wr_drop) begin
                ovf_q[trk_q] <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (rec_en_i) begin
                        state_q    <= S_REC;
                        trk_q      <= track_sel_i;
                        run_note_q <= note_i;
                        run_dur_q  <= '0;
                    end else if (play_start_i) begin
                        trk_q <= track_sel_i;
                        idx_q <= '0;
                        if (act_cnt != '0) begin
                            state_q <= S_PLAY;
                        end else begin
                            play_done_q <= 1'b1;
                        end
                    end else if (clear_i) begin
                        count_q[track_sel_i] <= '0;
                        ovf_q[track_sel_i]   <= 1'b0;
                    end
                end
                S_REC: begin
                    if (!rec_en_i) begin
                        state_q <= S_IDLE;
                    end else if (note_chg) begin
                        run_note_q <= note_i;
                        run_dur_q  <= tick_i ? DUR_WIDTH'(1) : '0;
                    end else if (tick_i) begin
                        run_dur_q <= dur_inc;
                    end
                end
                S_PLAY: begin
                    if (load_q) begin
                        out_valid_q <= 1'b1;
                        out_note_q  <= rd_q[EW-1:DUR_WIDTH];
                        out_dur_q   <= rd_q[DUR_WIDTH-1:0];
                    end
                    if (play_stop_i) begin
                        out_valid_q <= 1'b0;
                        load_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else if (accept) begin
                        out_valid_q <= 1'b0;
                        if (!last || loop_i) begin
                            idx_q <= idx_nxt;
                        end else begin
                            play_done_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_note_o  = out_note_q;
    assign out_dur_o   = out_dur_q;
    assign play_done_o = play_done_q;
    assign busy_o      = (state_q != S_IDLE);
    assign count_o     = act_cnt;
    assign full_o      = (act_cnt == CNT_FULL);
    assign overflow_o  = ovf_q[act_trk];

endmodule
`default_nettype wire

// File: tb/tb_note_track_recorder.sv
`default_nettype none
// ============================================================================
// tb_note_track_recorder : scoreboard bench for note_track_recorder
// Rev 1.0
// ============================================================================
module tb_note_track_recorder;

    localparam int DW  = 8;
    localparam int DP  = 4;
    localparam int DUR = 4;
    localparam int TR  = 2;
    localparam int TW  = 1;
    localparam int AW  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick_i;
    logic [TW-1:0] track_sel_i;
    logic          rec_en_i;
    logic [DW-1:0] note_i;
    logic          clear_i;
    logic          play_start_i;
    logic          play_stop_i;
    logic          loop_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_note_o;
    logic [DUR-1:0] out_dur_o;
    logic          play_done_o;
    logic          busy_o;
    logic          full_o;
    logic          overflow_o;
    logic [AW:0]   count_o;

    typedef struct packed {
        logic [DW-1:0]  n;
        logic [DUR-1:0] d;
    } ent_t;

    ent_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    note_track_recorder #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP),
        .DUR_WIDTH  (DUR),
        .TRACKS     (TR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_i       (tick_i),
        .track_sel_i  (track_sel_i),
        .rec_en_i     (rec_en_i),
        .note_i       (note_i),
        .clear_i      (clear_i),
        .play_start_i (play_start_i),
        .play_stop_i  (play_stop_i),
        .loop_i       (loop_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_note_o   (out_note_o),
        .out_dur_o    (out_dur_o),
        .play_done_o  (play_done_o),
        .busy_o       (busy_o),
        .full_o       (full_o),
        .overflow_o   (overflow_o),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int note, input int ticks);
        note_i = DW'(note);
        tick_i = 1'b0;
        step();
        repeat (ticks) begin
            tick_i = 1'b1;
            step();
            tick_i = 1'b0;
            step();
        end
    endtask

    task automatic push(input int n, input int d);
        ent_t e;
        e.n = DW'(n);
        e.d = DUR'(d);
        sb.push_back(e);
    endtask

    task automatic do_clear(input int t);
        track_sel_i = TW'(t);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    task automatic start_play();
        play_start_i = 1'b1;
        step();
        play_start_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!play_done_o && n < 60) begin
            step();
            n++;
        end
        chk(name, play_done_o, 1);
    endtask

    // Monitor: every handshake pops and compares one expected entry.
    always @(negedge clk) begin : mon
        ent_t e;
        if (!rst && out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_output", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("sb_note", int'(out_note_o), int'(e.n));
                chk("sb_dur", int'(out_dur_o), int'(e.d));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        int seen;
        rst = 1'b1; tick_i = 0; track_sel_i = 0; rec_en_i = 0; note_i = 0;
        clear_i = 0; play_start_i = 0; play_stop_i = 0; loop_i = 0; out_ready_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_note", out_note_o, 0);
        chk("rst_out_dur", out_dur_o, 0);
        chk("rst_play_done", play_done_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_full", full_o, 0);
        chk("rst_overflow", overflow_o, 0);
        chk("rst_count", count_o, 0);
        rst = 1'b0;
        step();

        // Empty track play
        start_play();
        chk("empty_play_done", play_done_o, 1);
        chk("empty_busy", busy_o, 0);
        step();
        chk("empty_done_pulse", play_done_o, 0);

        // Basic record/play
        rec_en_i = 1; note_i = 5;
        step();
        chk("rec_busy", busy_o, 1);
        feed(5, 3);
        feed(7, 2);
        rec_en_i = 0;
        step();
        chk("basic_count", count_o, 2);
        chk("basic_idle", busy_o, 0);
        push(5, 3); push(7, 2);
        out_ready_i = 1;
        start_play();
        chk("play_busy", busy_o, 1);
        chk("play_t1_valid", out_valid_o, 0);
        step();
        chk("play_t2_valid", out_valid_o, 1);
        chk("play_t2_note", out_note_o, 5);
        step();
        chk("play_bubble", out_valid_o, 0);
        step();
        chk("play_t4_valid", out_valid_o, 1);
        chk("play_t4_note", out_note_o, 7);
        step();
        chk("play_t5_done", play_done_o, 1);
        chk("play_t5_busy", busy_o, 0);
        chk("play_t5_valid", out_valid_o, 0);
        step();
        chk("play_done_pulse", play_done_o, 0);

        // Glitch filter
        do_clear(0);
        chk("clear_count", count_o, 0);
        rec_en_i = 1; note_i = 5;
        step();
        feed(5, 2);
        note_i = 9; step();
        note_i = 5; step();
        tick_i = 1; step();
        tick_i = 0; step();
        rec_en_i = 0; step();
        chk("glitch_count", count_o, 2);
        push(5, 2); push(5, 1);
        start_play();
        wait_done("glitch_done");

        // Full / overflow
        do_clear(0);
        rec_en_i = 1; note_i = 1;
        step();
        for (int i = 1; i <= 6; i++) feed(i, 1);
        rec_en_i = 0;
        step();
        chk("full_count", count_o, 4);
        chk("full_flag", full_o, 1);
        chk("full_overflow", overflow_o, 1);
        do_clear(0);
        chk("full_clr_count", count_o, 0);
        chk("full_clr_overflow", overflow_o, 0);
        chk("full_clr_full", full_o, 0);

        // Backpressure
        rec_en_i = 1; note_i = 3;
        step();
        feed(3, 1); feed(4, 2); feed(6, 1);
        rec_en_i = 0;
        step();
        chk("bp_count", count_o, 3);
        push(3, 1); push(4, 2); push(6, 1);
        out_ready_i = 0;
        start_play();
        step();
        chk("bp_valid", out_valid_o, 1);
        chk("bp_note0", out_note_o, 3);
        repeat (5) step();
        chk("bp_hold_valid", out_valid_o, 1);
        chk("bp_hold_note", out_note_o, 3);
        chk("bp_hold_dur", out_dur_o, 1);
        out_ready_i = 1;
        step();
        out_ready_i = 0;
        chk("bp_accept_bubble", out_valid_o, 0);
        step();
        chk("bp_next_note", out_note_o, 4);
        chk("bp_next_dur", out_dur_o, 2);
        repeat (3) step();
        chk("bp_hold2_note", out_note_o, 4);
        chk("bp_hold2_valid", out_valid_o, 1);
        out_ready_i = 1;
        wait_done("bp_done");
        chk("bp_sb_empty", sb.size(), 0);

        // Loop and stop on track 1
        do_clear(1);
        rec_en_i = 1; note_i = 8;
        step();
        feed(8, 1); feed(9, 2);
        rec_en_i = 0;
        step();
        chk("loop_count", count_o, 2);
        push(8, 1); push(9, 2); push(8, 1); push(9, 2); push(8, 1);
        loop_i = 1; out_ready_i = 1;
        start_play();
        seen = 0;
        repeat (10) begin
            step();
            seen |= int'(play_done_o);
        end
        chk("loop_no_done", seen, 0);
        out_ready_i = 0;
        step();
        chk("loop_wrap_valid", out_valid_o, 1);
        chk("loop_wrap_note", out_note_o, 9);
        play_stop_i = 1;
        step();
        play_stop_i = 0;
        chk("stop_valid", out_valid_o, 0);
        chk("stop_busy", busy_o, 0);
        chk("stop_no_done", play_done_o, 0);
        loop_i = 0;
        chk("loop_sb_empty", sb.size(), 0);

        // Track independence
        track_sel_i = 0;
        step();
        chk("trk0_count", count_o, 3);
        track_sel_i = 1;
        step();
        chk("trk1_count", count_o, 2);
        track_sel_i = 0;
        push(3, 1); push(4, 2); push(6, 1);
        out_ready_i = 1;
        start_play();
        wait_done("trk0_replay_done");

        // Duration saturation
        do_clear(0);
        rec_en_i = 1; note_i = 2;
        step();
        feed(2, 20);
        rec_en_i = 0;
        step();
        chk("sat_count", count_o, 1);
        push(2, 15);
        start_play();
        wait_done("sat_done");

        // Reset mid-record
        rec_en_i = 1; note_i = 4;
        step();
        feed(4, 2);
        feed(5, 1);
        rst = 1;
        #1;
        chk("rst_rec_busy", busy_o, 0);
        chk("rst_rec_count", count_o, 0);
        rst = 0; rec_en_i = 0;
        step();
        chk("rst_rec_count_after", count_o, 0);
        track_sel_i = 1;
        step();
        chk("rst_trk1_count", count_o, 0);

        chk("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
